// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronises the raw PS/2 lines, deserialises 11-bit frames
// and queues valid scan codes in a small FIFO drained by a ready / active-low pop handshake.
module ps2_rx_fifo #(
    parameter int FIFO_AW = 3,
    parameter int TIMEOUT = 50000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [2:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic [3:0]       bit_cnt;
    logic [9:0]       frame;
    logic [TW-1:0]    to_cnt;
    logic [FIFO_AW:0] w_ptr;
    logic [FIFO_AW:0] r_ptr;
    logic [7:0]       mem [DEPTH];

    logic fall;
    logic frame_done;
    logic frame_ok;
    logic empty;
    logic full;
    logic push;
    logic pop;

    // Falling edge of the synchronised PS/2 clock: oldest sample high, next one low.
    assign fall       = clk_sync[2] & ~clk_sync[1];
    assign frame_done = fall && (bit_cnt == 4'd10);
    // frame[0] is the start bit, frame[8:1] the byte, frame[9] odd parity; the stop bit is live.
    assign frame_ok   = ~frame[0] & dat_sync[1] & (^frame[9:1]);

    assign empty = (w_ptr == r_ptr);
    assign full  = (w_ptr[FIFO_AW] != r_ptr[FIFO_AW]) &&
                   (w_ptr[FIFO_AW-1:0] == r_ptr[FIFO_AW-1:0]);
    assign push  = frame_done & frame_ok & ~full;
    assign pop   = ~nextdata_n & ~empty;

    assign ready = ~empty;
    assign data  = empty ? 8'h00 : mem[r_ptr[FIFO_AW-1:0]];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync  <= 3'b111;
            dat_sync  <= 2'b11;
            bit_cnt   <= 4'd0;
            frame     <= 10'd0;
            to_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            clk_sync  <= {clk_sync[1:0], ps2_clk};
            dat_sync  <= {dat_sync[0], ps2_data};
            frame_err <= frame_done & ~frame_ok;
            if (fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd10) begin
                    bit_cnt <= 4'd0;
                end else begin
                    frame[bit_cnt] <= dat_sync[1];
                    bit_cnt        <= bit_cnt + 4'd1;
                end
            end else if (bit_cnt != 4'd0) begin
                // A stalled partial frame is dropped silently so the next frame starts clean.
                if (to_cnt == TO_LAST) begin
                    bit_cnt <= 4'd0;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            w_ptr    <= '0;
            r_ptr    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) w_ptr <= w_ptr + 1'b1;
            if (pop)  r_ptr <= r_ptr + 1'b1;
            // Full is judged before this cycle's pop, so a drop wins over a same-cycle clear.
            if (frame_done && frame_ok && full) overflow <= 1'b1;
            else if (pop)                        overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[w_ptr[FIFO_AW-1:0]] <= frame[8:1];
    end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed scenarios plus random frames, checked against a queue model.
module tb_ps2_rx_fifo;

    localparam int TO    = 300;
    localparam int HALF  = 10;
    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready;
    logic       overflow;
    logic       frame_err;

    int pass_cnt = 0;
    int total_cnt = 0;
    int fail_cnt = 0;
    int ferr_total = 0;

    logic [7:0] exp_q[$];
    logic       exp_ovf = 1'b0;

    ps2_rx_fifo #(.FIFO_AW(3), .TIMEOUT(TO)) dut (
        .clk(clk), .clrn(clrn), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .data(data), .ready(ready),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (frame_err === 1'b1) ferr_total++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input bit bad_par, input bit bad_stop);
        logic par;
        par = (~^d) ^ bad_par;
        return {~bad_stop, par, d, 1'b0};
    endfunction

    task automatic ps2_bits(input logic [10:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = b[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
    endtask

    task automatic check_state(input string tag);
        logic [7:0] exp_d;
        exp_d = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
        check({tag, "_ready"}, ready, (exp_q.size() != 0));
        check({tag, "_data"}, data, exp_d);
        check({tag, "_ovf"}, overflow, exp_ovf);
    endtask

    task automatic send_checked(input string tag, input logic [7:0] d, input bit bp, input bit bs);
        int f0;
        f0 = ferr_total;
        ps2_bits(mk(d, bp, bs), 11);
        repeat (5) @(negedge clk);
        if (!bp && !bs) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else exp_ovf = 1'b1;
        end
        check({tag, "_ferr"}, ferr_total - f0, (bp || bs) ? 1 : 0);
        check_state(tag);
    endtask

    task automatic pop1(input string tag);
        @(negedge clk);
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
        if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            exp_ovf = 1'b0;
        end
        check_state(tag);
    endtask

    initial begin
        logic [10:0] b;
        int lat;
        int f0;
        logic [7:0] rd;
        int kind;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_ready", ready, 1'b0);
        check("rst_data", data, 8'h00);
        check("rst_ovf", overflow, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        clrn = 1'b1;
        repeat (3) @(negedge clk);

        // Single frame 0x1C with push latency measured from the final pin edge
        f0 = ferr_total;
        b = mk(8'h1C, 1'b0, 1'b0);
        ps2_bits(b, 10);
        @(negedge clk);
        ps2_data = b[10];
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        lat = 0;
        while (ready !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        check("t1_latency_ok", (lat >= 3 && lat <= 4), 1'b1);
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.push_back(8'h1C);
        check_state("t1");
        check("t1_ferr", ferr_total - f0, 0);
        pop1("t1_pop");

        // Two frames back to back, then drain
        send_checked("t2a", 8'hF0, 1'b0, 1'b0);
        send_checked("t2b", 8'h1C, 1'b0, 1'b0);
        pop1("t2_pop1");
        pop1("t2_pop2");

        // Bad parity and bad stop
        send_checked("t3_par", 8'h1C, 1'b1, 1'b0);
        send_checked("t3_stop", 8'h1C, 1'b0, 1'b1);

        // Overflow: nine frames into an eight-entry FIFO
        for (int i = 1; i <= 9; i++) send_checked("t4_fill", 8'(i), 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) pop1("t4_drain");

        // Stalled partial frame discarded by the timeout
        f0 = ferr_total;
        ps2_bits(mk(8'hA5, 1'b0, 1'b0), 5);
        repeat (TO + 10) @(negedge clk);
        send_checked("t5", 8'h45, 1'b0, 1'b0);
        check("t5_ferr_total", ferr_total - f0, 0);
        pop1("t5_pop");

        // Reset mid-frame with bytes queued
        send_checked("t6a", 8'h33, 1'b0, 1'b0);
        send_checked("t6b", 8'h44, 1'b0, 1'b0);
        ps2_bits(mk(8'h77, 1'b0, 1'b0), 4);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        check("t6_rst_ready", ready, 1'b0);
        check("t6_rst_ovf", overflow, 1'b0);
        exp_q.delete();
        exp_ovf = 1'b0;
        repeat (2) @(negedge clk);
        clrn = 1'b1;
        repeat (2) @(negedge clk);
        send_checked("t6c", 8'h16, 1'b0, 1'b0);
        pop1("t6_pop");

        // Random frames with occasional corruption and sparse pops
        for (int n = 0; n < 24; n++) begin
            rd = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 7);
            send_checked("rnd", rd, (kind == 0), (kind == 1));
            if ($urandom_range(0, 2) == 0) pop1("rnd_pop");
        end
        while (exp_q.size() != 0) pop1("rnd_drain");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
